aidan_mcnay_trial_div_ctrl: RTL and testbench

Trial-division sequencer that decides primality of an unsigned candidate. It is the initiator on the divider's val/rdy stream interface: it drives operand pairs (n, d) into the divider's input stream and consumes quotients from the divider's output stream. The divider may be combinational or multi-cycle. Results leave on a val/rdy response stream toward the top-level prime-detection logic.

---
 rtl/aidan_mcnay_trial_div_ctrl.sv | 147 ++++++++++++++
 tb/tb_aidan_mcnay_trial_div_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_trial_div_ctrl.sv
// Trial-division primality sequencer: feeds (n, d) pairs to an external val/rdy
// divider and reports whether n is prime, or its smallest factor if composite.
module aidan_mcnay_trial_div_ctrl #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [nbits-1:0] req_n,
  input  logic             req_val,
  output logic             req_rdy,

  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_istream_val,
  input  logic             div_istream_rdy,

  input  logic [nbits-1:0] div_result,
  input  logic             div_ostream_val,
  output logic             div_ostream_rdy,

  output logic             resp_prime,
  output logic [nbits-1:0] resp_factor,
  output logic             resp_val,
  input  logic             resp_rdy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [nbits-1:0] ONE = nbits'(1);
  localparam logic [nbits-1:0] TWO = nbits'(2);

  state_t             state;
  logic [nbits-1:0]   n;
  logic [nbits-1:0]   d;
  logic               sent;
  logic               prime;
  logic [nbits-1:0]   factor;

  logic               istream_fire;
  logic               ostream_fire;
  logic               quotient_ok;
  logic [2*nbits-1:0] product;
  logic               found_prime;
  logic               found_factor;

  assign div_opa     = n;
  assign div_opb     = d;
  assign resp_prime  = prime;
  assign resp_factor = factor;

  assign istream_fire = div_istream_val && div_istream_rdy;
  assign ostream_fire = div_ostream_val && div_ostream_rdy;

  // A quotient only counts if its operand pair was sent, possibly this same cycle.
  assign quotient_ok  = ostream_fire && (sent || istream_fire);

  assign product      = (2*nbits)'(div_result) * (2*nbits)'(d);
  assign found_prime  = div_result < d;
  assign found_factor = product == (2*nbits)'(n);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      n               <= '0;
      d               <= TWO;
      sent            <= 1'b0;
      prime           <= 1'b0;
      factor          <= '0;
      req_rdy         <= 1'b1;
      div_istream_val <= 1'b0;
      div_ostream_rdy <= 1'b0;
      resp_val        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            n       <= req_n;
            d       <= TWO;
            sent    <= 1'b0;
            req_rdy <= 1'b0;
            if (req_n < TWO) begin
              prime    <= 1'b0;
              factor   <= '0;
              resp_val <= 1'b1;
              state    <= DONE;
            end else begin
              div_istream_val <= 1'b1;
              div_ostream_rdy <= 1'b1;
              state           <= CALC;
            end
          end
        end

        CALC: begin
          if (istream_fire) begin
            sent            <= 1'b1;
            div_istream_val <= 1'b0;
          end
          // Quotient below divisor means no factor <= sqrt(n) remains untried.
          if (quotient_ok) begin
            if (found_prime) begin
              prime           <= 1'b1;
              factor          <= '0;
              div_istream_val <= 1'b0;
              div_ostream_rdy <= 1'b0;
              resp_val        <= 1'b1;
              state           <= DONE;
            end else if (found_factor) begin
              prime           <= 1'b0;
              factor          <= d;
              div_istream_val <= 1'b0;
              div_ostream_rdy <= 1'b0;
              resp_val        <= 1'b1;
              state           <= DONE;
            end else begin
              d               <= d + ONE;
              sent            <= 1'b0;
              div_istream_val <= 1'b1;
            end
          end
        end

        DONE: begin
          if (resp_rdy) begin
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state           <= IDLE;
          req_rdy         <= 1'b1;
          div_istream_val <= 1'b0;
          div_ostream_rdy <= 1'b0;
          resp_val        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_trial_div_ctrl.sv
// Self-checking bench for the trial-division controller, with a divider model
// that runs either combinationally or with a 3-cycle latency and random stalls.
module tb_aidan_mcnay_trial_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req_n;
  logic        req_val;
  logic        req_rdy;
  logic [15:0] div_opa;
  logic [15:0] div_opb;
  logic        div_istream_val;
  logic        div_istream_rdy;
  logic [15:0] div_result;
  logic        div_ostream_val;
  logic        div_ostream_rdy;
  logic        resp_prime;
  logic [15:0] resp_factor;
  logic        resp_val;
  logic        resp_rdy;

  int n_checks;
  int n_fail;

  aidan_mcnay_trial_div_ctrl #(.nbits(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_n          (req_n),
    .req_val        (req_val),
    .req_rdy        (req_rdy),
    .div_opa        (div_opa),
    .div_opb        (div_opb),
    .div_istream_val(div_istream_val),
    .div_istream_rdy(div_istream_rdy),
    .div_result     (div_result),
    .div_ostream_val(div_ostream_val),
    .div_ostream_rdy(div_ostream_rdy),
    .resp_prime     (resp_prime),
    .resp_factor    (resp_factor),
    .resp_val       (resp_val),
    .resp_rdy       (resp_rdy)
  );

  always #5 clk = ~clk;

  // Divider model
  logic        comb_mode;
  logic        busy = 1'b0;
  logic [1:0]  cnt = 2'd0;
  logic [15:0] held_q = 16'd0;
  logic        stall_ok = 1'b1;

  assign div_istream_rdy = comb_mode ? 1'b1 : (!busy && stall_ok);
  assign div_ostream_val = comb_mode ? div_istream_val : (busy && cnt == 2'd0);
  assign div_result      = comb_mode ? ((div_opb == 16'd0) ? 16'd0 : div_opa / div_opb) : held_q;

  always @(posedge clk) begin
    stall_ok <= ($urandom_range(0, 3) != 0);
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= 2'd0;
    end else if (!comb_mode) begin
      if (busy) begin
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
        else if (div_ostream_rdy) busy <= 1'b0;
      end else if (div_istream_val && div_istream_rdy) begin
        busy   <= 1'b1;
        cnt    <= 2'd2;
        held_q <= div_opa / div_opb;
      end
    end
  end

  // Protocol monitor: transaction counts, outstanding limit, payload stability
  wire ifire = div_istream_val && div_istream_rdy;
  wire ofire = div_ostream_val && div_ostream_rdy;
  wire rfire = resp_val && resp_rdy;

  int          ifire_cnt = 0;
  int          outst = 0;
  int          outst_err = 0;
  int          stab_err = 0;
  int          resp_err = 0;
  logic        have_prev = 1'b0;
  logic        prev_ival = 1'b0, prev_ifire = 1'b0, prev_rval = 1'b0, prev_rfire = 1'b0, prev_rp = 1'b0;
  logic [15:0] prev_opa = 16'd0, prev_opb = 16'd0, prev_rf = 16'd0;

  always @(posedge clk) begin
    if (!reset) begin
      outst     <= 0;
      have_prev <= 1'b0;
    end else begin
      if (ifire) ifire_cnt <= ifire_cnt + 1;
      if ((ofire && outst == 0 && !ifire) || (outst + int'(ifire) > 1))
        outst_err <= outst_err + 1;
      outst <= outst + int'(ifire) - int'(ofire);
      if (have_prev && prev_ival && !prev_ifire &&
          (!div_istream_val || div_opa != prev_opa || div_opb != prev_opb))
        stab_err <= stab_err + 1;
      if (have_prev && prev_rval && !prev_rfire &&
          (!resp_val || resp_prime != prev_rp || resp_factor != prev_rf))
        resp_err <= resp_err + 1;
      have_prev <= 1'b1;
    end
    prev_ival  <= div_istream_val;
    prev_ifire <= ifire;
    prev_opa   <= div_opa;
    prev_opb   <= div_opb;
    prev_rval  <= resp_val;
    prev_rfire <= rfire;
    prev_rp    <= resp_prime;
    prev_rf    <= resp_factor;
  end

  // Reference model and scoreboard
  typedef struct {
    int          n;
    logic        prime;
    logic [15:0] factor;
    int          trials;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input int n);
    exp_t e;
    int   d;
    bit   stop;
    e.n = n; e.prime = 1'b0; e.factor = 16'd0; e.trials = 0; e.cycles = 1;
    if (n >= 2) begin
      d = 2;
      stop = 1'b0;
      while (!stop) begin
        if (d * d > n) begin
          e.prime = 1'b1;
          stop = 1'b1;
        end else if (n % d == 0) begin
          e.factor = 16'(d);
          stop = 1'b1;
        end else begin
          d++;
        end
      end
      e.trials = d - 1;
      e.cycles = e.trials + 1;
    end
    return e;
  endfunction

  // Drives one request, waits for its response and returns what was observed
  task automatic do_req(input int n, input bit bp, output logic p, output logic [15:0] f,
                        output int cyc, output int trials, output int waited, output bit tmo);
    int i0;
    int k;
    tmo = 1'b0; waited = 0; cyc = 0; trials = 0; p = 1'bx; f = 16'hxxxx;
    @(negedge clk);
    while (req_rdy !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (req_rdy !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    req_n   = 16'(n);
    req_val = 1'b1;
    i0      = ifire_cnt;
    @(posedge clk);
    #1;
    req_val = 1'b0;
    cyc = 1;
    while (resp_val !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (resp_val !== 1'b1) begin
      tmo = 1'b1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      return;
    end
    p = resp_prime;
    f = resp_factor;
    if (bp) begin
      k = 0;
      do begin
        @(negedge clk);
        resp_rdy = (k >= 20) || ($urandom_range(0, 2) == 0);
        @(posedge clk);
        k++;
      end while (!resp_rdy);
    end else begin
      @(negedge clk);
      resp_rdy = 1'b1;
      @(posedge clk);
    end
    #1;
    resp_rdy = 1'b0;
    trials = ifire_cnt - i0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_rdy: got %b, expected 1", req_rdy); end
    n_checks++; if (div_istream_val !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_istream_val: got %b, expected 0", div_istream_val); end
    n_checks++; if (div_ostream_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ostream_rdy: got %b, expected 0", div_ostream_rdy); end
    n_checks++; if (resp_val !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_val: got %b, expected 0", resp_val); end
    n_checks++; if (resp_prime !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_prime: got %b, expected 0", resp_prime); end
    n_checks++; if (resp_factor !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_resp_factor: got %0d, expected 0", resp_factor); end
    n_checks++; if (div_opb !== 16'd2) begin n_fail++; $display("[TB] FAIL reset_div_opb: got %0d, expected 2", div_opb); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs a list of candidates through the combinational divider and checks
  // result, exact cycle latency and divider transaction count
  task automatic test_comb_list(input string name, input int ns[$]);
    exp_t        e;
    logic        p;
    logic [15:0] f;
    int          cyc, trials, waited;
    bit          tmo;
    comb_mode = 1'b1;
    foreach (ns[i]) begin
      sb.push_back(model(ns[i]));
      do_req(ns[i], 1'b0, p, f, cyc, trials, waited, tmo);
      e = sb.pop_front();
      n_checks++; if (tmo) begin n_fail++; $display("[TB] FAIL %s_timeout n=%0d: got timeout, expected response", name, e.n); end
      n_checks++; if (p !== e.prime) begin n_fail++; $display("[TB] FAIL %s_prime n=%0d: got %b, expected %b", name, e.n, p, e.prime); end
      n_checks++; if (f !== e.factor) begin n_fail++; $display("[TB] FAIL %s_factor n=%0d: got %0d, expected %0d", name, e.n, f, e.factor); end
      n_checks++; if (cyc != e.cycles) begin n_fail++; $display("[TB] FAIL %s_latency n=%0d: got cycle %0d, expected cycle %0d", name, e.n, cyc, e.cycles); end
      n_checks++; if (trials != e.trials) begin n_fail++; $display("[TB] FAIL %s_trials n=%0d: got %0d, expected %0d", name, e.n, trials, e.trials); end
    end
  endtask

  task automatic test_trivial();
    test_comb_list("trivial", '{0, 1});
  endtask

  task automatic test_small_primes();
    test_comb_list("small_prime", '{2, 3, 7});
  endtask

  task automatic test_composites();
    test_comb_list("composite", '{4, 25, 65535, 49});
  endtask

  task automatic test_largest_prime();
    test_comb_list("largest_prime", '{65521});
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic        p;
    logic [15:0] f;
    int          cyc, trials, waited;
    bit          tmo;
    int          ns[3] = '{13, 15, 0};
    comb_mode = 1'b1;
    foreach (ns[i]) begin
      sb.push_back(model(ns[i]));
      do_req(ns[i], 1'b0, p, f, cyc, trials, waited, tmo);
      e = sb.pop_front();
      n_checks++; if (tmo || p !== e.prime || f !== e.factor) begin n_fail++; $display("[TB] FAIL b2b_result n=%0d: got prime=%b factor=%0d, expected prime=%b factor=%0d", e.n, p, f, e.prime, e.factor); end
      n_checks++; if (waited != 0) begin n_fail++; $display("[TB] FAIL b2b_req_rdy n=%0d: got %0d idle cycles before accept, expected 0", e.n, waited); end
    end
  endtask

  task automatic test_multicycle();
    exp_t        e;
    logic        p;
    logic [15:0] f;
    int          cyc, trials, waited;
    bit          tmo;
    int          s0, r0, o0;
    int          ns[$];
    s0 = stab_err; r0 = resp_err; o0 = outst_err;
    comb_mode = 1'b0;
    ns.push_back(91);
    for (int i = 0; i < 5; i++) ns.push_back(int'($urandom_range(2, 3000)));
    foreach (ns[i]) begin
      sb.push_back(model(ns[i]));
      do_req(ns[i], 1'b1, p, f, cyc, trials, waited, tmo);
      e = sb.pop_front();
      n_checks++; if (tmo) begin n_fail++; $display("[TB] FAIL multi_timeout n=%0d: got timeout, expected response", e.n); end
      n_checks++; if (p !== e.prime) begin n_fail++; $display("[TB] FAIL multi_prime n=%0d: got %b, expected %b", e.n, p, e.prime); end
      n_checks++; if (f !== e.factor) begin n_fail++; $display("[TB] FAIL multi_factor n=%0d: got %0d, expected %0d", e.n, f, e.factor); end
      n_checks++; if (trials != e.trials) begin n_fail++; $display("[TB] FAIL multi_trials n=%0d: got %0d, expected %0d", e.n, trials, e.trials); end
      n_checks++; if (!tmo && cyc < 4 * e.trials + 1) begin n_fail++; $display("[TB] FAIL multi_latency n=%0d: got cycle %0d, expected at least %0d", e.n, cyc, 4 * e.trials + 1); end
    end
    n_checks++; if (stab_err != s0) begin n_fail++; $display("[TB] FAIL istream_stable: got %0d violations, expected 0", stab_err - s0); end
    n_checks++; if (resp_err != r0) begin n_fail++; $display("[TB] FAIL resp_stable: got %0d violations, expected 0", resp_err - r0); end
    n_checks++; if (outst_err != o0) begin n_fail++; $display("[TB] FAIL outstanding: got %0d violations, expected 0", outst_err - o0); end
    comb_mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    logic        p;
    logic [15:0] f;
    int          cyc, trials, waited;
    bit          tmo;
    comb_mode = 1'b1;
    @(negedge clk);
    req_n   = 16'd65521;
    req_val = 1'b1;
    @(posedge clk);
    #1;
    req_val = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (req_rdy !== 1'b0 || resp_val !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_calc_busy: got req_rdy=%b resp_val=%b, expected 0 0", req_rdy, resp_val); end
    n_checks++; if (div_opb !== 16'd22) begin n_fail++; $display("[TB] FAIL mid_calc_divisor: got %0d, expected 22", div_opb); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (req_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_req_rdy: got %b, expected 1", req_rdy); end
    n_checks++; if (resp_val !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_resp_val: got %b, expected 0", resp_val); end
    n_checks++; if (div_istream_val !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_istream_val: got %b, expected 0", div_istream_val); end
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(model(9));
    do_req(9, 1'b0, p, f, cyc, trials, waited, tmo);
    e = sb.pop_front();
    n_checks++; if (tmo || p !== e.prime || f !== e.factor) begin n_fail++; $display("[TB] FAIL after_abort n=9: got prime=%b factor=%0d, expected prime=%b factor=%0d", p, f, e.prime, e.factor); end
    n_checks++; if (trials != e.trials) begin n_fail++; $display("[TB] FAIL after_abort_trials n=9: got %0d, expected %0d", trials, e.trials); end
  endtask

  initial begin
    reset     = 1'b0;
    req_val   = 1'b0;
    req_n     = 16'd0;
    resp_rdy  = 1'b0;
    comb_mode = 1'b1;
    n_checks  = 0;
    n_fail    = 0;
    test_reset();
    test_trivial();
    test_small_primes();
    test_composites();
    test_largest_prime();
    test_back_to_back();
    test_multicycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
